csr_exec_unit: RTL and testbench

CSR_EXEC_UNIT -- requirements
Module: csr_exec_unit

---
 rtl/csr_exec_unit.sv | 181 ++++++++++++++++++
 tb/tb_csr_exec_unit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/csr_exec_unit.sv
// Single-issue CSR execution unit: read-modify-write of machine CSRs with one-cycle writeback.
// Optional hardware counters (mcycle/minstret) are built only when CSR_COUNTER_EN is defined.
module csr_exec_unit #(
    parameter int ROB_WIDTH  = 5,
    parameter int PREG_WIDTH = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_en,
    input  logic [2:0]            issue_funct,
    input  logic [11:0]           issue_csrid,
    input  logic [4:0]            issue_uimm,
    input  logic [31:0]           issue_rdata,
    input  logic                  issue_srcZero,
    input  logic                  issue_we,
    input  logic [PREG_WIDTH-1:0] issue_rd,
    input  logic [ROB_WIDTH:0]    issue_robIdx,
    input  logic                  redirect,
    input  logic [ROB_WIDTH:0]    redirectIdx,
    input  logic [2:0]            commit_num,
    output logic                  wb_en,
    output logic [PREG_WIDTH-1:0] wb_rd,
    output logic [31:0]           wb_data,
    output logic [ROB_WIDTH:0]    wb_robIdx,
    output logic                  exc_en,
    output logic [4:0]            exc_cause,
    output logic [ROB_WIDTH:0]    exc_robIdx
);

    localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
    localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET = 12'hB02;
    localparam logic [11:0] ADDR_MHARTID  = 12'hF14;

    localparam logic [31:0] MSTATUS_MASK  = 32'h0000_1888;
    localparam logic [31:0] MSTATUS_RESET = 32'h0000_1800;
    localparam logic [4:0]  CAUSE_ILLEGAL = 5'd2;

    logic [31:0] mstatus;
    logic [31:0] mtvec;
    logic [31:0] mscratch;
    logic [31:0] mepc;
    logic [31:0] mcause;

    logic [31:0] src;
    logic [31:0] old_val;
    logic [31:0] new_val;
    logic        hit;
    logic        op_rw;
    logic        funct_ok;
    logic        wr_attempt;
    logic        read_only;
    logic        flushed;
    logic        illegal;
    logic        do_write;

    // Tag a is older than tag b; the MSB is a wrap bit, so differing MSBs invert the compare.
    function automatic logic is_older(input logic [ROB_WIDTH:0] a, input logic [ROB_WIDTH:0] b);
        if (a[ROB_WIDTH] == b[ROB_WIDTH])
            return a[ROB_WIDTH-1:0] < b[ROB_WIDTH-1:0];
        else
            return a[ROB_WIDTH-1:0] > b[ROB_WIDTH-1:0];
    endfunction

`ifdef CSR_COUNTER_EN
    logic [31:0] mcycle;
    logic [31:0] minstret;
`else
    logic unused_commit;
    assign unused_commit = ^commit_num;
`endif

    always_comb begin
        hit     = 1'b1;
        old_val = 32'h0;
        case (issue_csrid)
            ADDR_MSTATUS:  old_val = mstatus;
            ADDR_MTVEC:    old_val = mtvec;
            ADDR_MSCRATCH: old_val = mscratch;
            ADDR_MEPC:     old_val = mepc;
            ADDR_MCAUSE:   old_val = mcause;
`ifdef CSR_COUNTER_EN
            ADDR_MCYCLE:   old_val = mcycle;
            ADDR_MINSTRET: old_val = minstret;
`endif
            ADDR_MHARTID:  old_val = 32'h0;
            default:       hit     = 1'b0;
        endcase
    end

    always_comb begin
        src = issue_funct[2] ? {27'b0, issue_uimm} : issue_rdata;
        case (issue_funct[1:0])
            2'b01:   new_val = src;
            2'b10:   new_val = old_val | src;
            2'b11:   new_val = old_val & ~src;
            default: new_val = old_val;
        endcase
    end

    always_comb begin
        op_rw      = (issue_funct[1:0] == 2'b01);
        funct_ok   = (issue_funct[1:0] != 2'b00);
        wr_attempt = op_rw || !issue_srcZero;
        read_only  = (issue_csrid[11:10] == 2'b11);
        flushed    = redirect && !is_older(issue_robIdx, redirectIdx);
        illegal    = !funct_ok || !hit || (wr_attempt && read_only);
        do_write   = issue_en && !flushed && !illegal && wr_attempt;
    end

    // Flushed ops vanish entirely: neither writeback nor exception is reported for them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_en      <= 1'b0;
            wb_rd      <= '0;
            wb_data    <= 32'h0;
            wb_robIdx  <= '0;
            exc_en     <= 1'b0;
            exc_cause  <= 5'd0;
            exc_robIdx <= '0;
        end else begin
            wb_en  <= 1'b0;
            exc_en <= 1'b0;
            if (issue_en && !flushed) begin
                if (illegal) begin
                    exc_en     <= 1'b1;
                    exc_cause  <= CAUSE_ILLEGAL;
                    exc_robIdx <= issue_robIdx;
                end else begin
                    wb_en     <= issue_we;
                    wb_rd     <= issue_rd;
                    wb_data   <= old_val;
                    wb_robIdx <= issue_robIdx;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mstatus  <= MSTATUS_RESET;
            mtvec    <= 32'h0;
            mscratch <= 32'h0;
            mepc     <= 32'h0;
            mcause   <= 32'h0;
        end else if (do_write) begin
            case (issue_csrid)
                ADDR_MSTATUS:  mstatus  <= new_val & MSTATUS_MASK;
                ADDR_MTVEC:    mtvec    <= {new_val[31:2], 2'b00};
                ADDR_MSCRATCH: mscratch <= new_val;
                ADDR_MEPC:     mepc     <= {new_val[31:2], 2'b00};
                ADDR_MCAUSE:   mcause   <= new_val;
                default:       ;
            endcase
        end
    end

`ifdef CSR_COUNTER_EN
    // A software write in the same cycle replaces that cycle's increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcycle   <= 32'h0;
            minstret <= 32'h0;
        end else begin
            if (do_write && issue_csrid == ADDR_MCYCLE)
                mcycle <= new_val;
            else
                mcycle <= mcycle + 32'd1;
            if (do_write && issue_csrid == ADDR_MINSTRET)
                minstret <= new_val;
            else
                minstret <= minstret + {29'b0, commit_num};
        end
    end
`endif

endmodule

// File: tb/tb_csr_exec_unit.sv
// Directed self-checking bench for csr_exec_unit; counter checks follow CSR_COUNTER_EN.
module tb_csr_exec_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_en;
    logic [2:0]  issue_funct;
    logic [11:0] issue_csrid;
    logic [4:0]  issue_uimm;
    logic [31:0] issue_rdata;
    logic        issue_srcZero;
    logic        issue_we;
    logic [6:0]  issue_rd;
    logic [5:0]  issue_robIdx;
    logic        redirect;
    logic [5:0]  redirectIdx;
    logic [2:0]  commit_num;
    logic        wb_en;
    logic [6:0]  wb_rd;
    logic [31:0] wb_data;
    logic [5:0]  wb_robIdx;
    logic        exc_en;
    logic [4:0]  exc_cause;
    logic [5:0]  exc_robIdx;

    int checks   = 0;
    int failures = 0;

    csr_exec_unit #(.ROB_WIDTH(5), .PREG_WIDTH(7)) dut (
        .clk(clk), .rst(rst),
        .issue_en(issue_en), .issue_funct(issue_funct), .issue_csrid(issue_csrid),
        .issue_uimm(issue_uimm), .issue_rdata(issue_rdata), .issue_srcZero(issue_srcZero),
        .issue_we(issue_we), .issue_rd(issue_rd), .issue_robIdx(issue_robIdx),
        .redirect(redirect), .redirectIdx(redirectIdx), .commit_num(commit_num),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .wb_robIdx(wb_robIdx),
        .exc_en(exc_en), .exc_cause(exc_cause), .exc_robIdx(exc_robIdx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Presents one op for one cycle, returns #1 after the edge with the result on the outputs.
    task automatic do_op(input logic [2:0] f, input logic [11:0] id, input logic [31:0] val,
                         input logic zero, input logic [5:0] rob);
        issue_en      = 1'b1;
        issue_funct   = f;
        issue_csrid   = id;
        issue_rdata   = val;
        issue_uimm    = val[4:0];
        issue_srcZero = zero;
        issue_robIdx  = rob;
        @(posedge clk);
        #1;
        issue_en = 1'b0;
        redirect = 1'b0;
    endtask

    task automatic idle();
        issue_en = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        issue_en = 1'b1; issue_funct = 3'b001; issue_csrid = 12'h340; issue_uimm = 5'd0;
        issue_rdata = 32'hBAD0BAD0; issue_srcZero = 1'b0; issue_we = 1'b1; issue_rd = 7'd9;
        issue_robIdx = 6'd0; redirect = 1'b0; redirectIdx = 6'd0; commit_num = 3'd0;
        #23;
        check("rst_wb_en", {31'b0, wb_en}, 32'h0);
        check("rst_exc_en", {31'b0, exc_en}, 32'h0);
        check("rst_wb_data", wb_data, 32'h0);
        @(posedge clk); #1;
        issue_en = 1'b0;
        rst = 1'b1;

        do_op(3'b010, 12'h300, 32'h0, 1'b1, 6'd4);
        check("mstatus_reset", wb_data, 32'h0000_1800);
        check("wb_en_read", {31'b0, wb_en}, 32'h1);
        check("wb_rd", {25'b0, wb_rd}, 32'd9);
        check("wb_robIdx", {26'b0, wb_robIdx}, 32'd4);

        do_op(3'b001, 12'h340, 32'hDEADBEEF, 1'b0, 6'd5);
        check("mscratch_rw_old", wb_data, 32'h0);
        do_op(3'b010, 12'h340, 32'h0, 1'b1, 6'd6);
        check("mscratch_rs_read", wb_data, 32'hDEADBEEF);
        do_op(3'b010, 12'h340, 32'h0, 1'b1, 6'd7);
        check("mscratch_unchanged", wb_data, 32'hDEADBEEF);

        do_op(3'b011, 12'h300, 32'h0000_1808, 1'b0, 6'd8);
        check("mstatus_rc_old", wb_data, 32'h0000_1800);
        do_op(3'b010, 12'h300, 32'h0, 1'b1, 6'd9);
        check("mstatus_after_rc", wb_data, 32'h0);
        do_op(3'b001, 12'h300, 32'hFFFFFFFF, 1'b0, 6'd10);
        do_op(3'b010, 12'h300, 32'h0, 1'b1, 6'd11);
        check("mstatus_mask", wb_data, 32'h0000_1888);

        do_op(3'b001, 12'h305, 32'h12345677, 1'b0, 6'd12);
        do_op(3'b010, 12'h305, 32'h0, 1'b1, 6'd13);
        check("mtvec_align", wb_data, 32'h12345674);
        do_op(3'b101, 12'h341, 32'h0000001F, 1'b0, 6'd14);
        do_op(3'b110, 12'h341, 32'h0, 1'b1, 6'd15);
        check("mepc_uimm_align", wb_data, 32'h0000001C);

        do_op(3'b010, 12'h342, 32'h5, 1'b0, 6'd16);
        do_op(3'b011, 12'h342, 32'h4, 1'b1, 6'd17);
        check("mcause_rs", wb_data, 32'h5);
        do_op(3'b010, 12'h342, 32'h0, 1'b1, 6'd18);
        check("mcause_rc_srczero_nowrite", wb_data, 32'h5);

        do_op(3'b001, 12'hF14, 32'h1, 1'b0, 6'd19);
        check("mhartid_wr_exc", {31'b0, exc_en}, 32'h1);
        check("mhartid_wr_cause", {27'b0, exc_cause}, 32'd2);
        check("mhartid_wr_tag", {26'b0, exc_robIdx}, 32'd19);
        check("mhartid_wr_wb_en", {31'b0, wb_en}, 32'h0);
        do_op(3'b010, 12'hF14, 32'h0, 1'b1, 6'd20);
        check("mhartid_rd_data", wb_data, 32'h0);
        check("mhartid_rd_exc", {31'b0, exc_en}, 32'h0);
        check("mhartid_rd_wb_en", {31'b0, wb_en}, 32'h1);

        do_op(3'b000, 12'h340, 32'h0, 1'b1, 6'd21);
        check("funct00_exc", {31'b0, exc_en}, 32'h1);
        do_op(3'b010, 12'h7C0, 32'h0, 1'b1, 6'd22);
        check("unsupported_exc", {31'b0, exc_en}, 32'h1);
        check("unsupported_wb_en", {31'b0, wb_en}, 32'h0);

        redirect = 1'b1; redirectIdx = 6'h03;
        do_op(3'b001, 12'h340, 32'h11111111, 1'b0, 6'h05);
        check("flush_younger_wb", {31'b0, wb_en}, 32'h0);
        check("flush_younger_exc", {31'b0, exc_en}, 32'h0);
        redirect = 1'b1; redirectIdx = 6'h03;
        do_op(3'b001, 12'h340, 32'h22222222, 1'b0, 6'h02);
        check("older_completes_wb", {31'b0, wb_en}, 32'h1);
        check("older_completes_data", wb_data, 32'hDEADBEEF);
        redirect = 1'b1; redirectIdx = 6'h3E;
        do_op(3'b001, 12'h340, 32'h33333333, 1'b0, 6'h01);
        check("flush_wrap_wb", {31'b0, wb_en}, 32'h0);
        redirect = 1'b1; redirectIdx = 6'h05;
        do_op(3'b000, 12'h340, 32'h0, 1'b1, 6'h05);
        check("flush_equal_exc", {31'b0, exc_en}, 32'h0);
        do_op(3'b010, 12'h340, 32'h0, 1'b1, 6'd23);
        check("mscratch_after_flush", wb_data, 32'h22222222);

        issue_we = 1'b0;
        do_op(3'b010, 12'h340, 32'h0, 1'b1, 6'd24);
        check("we0_wb_en", {31'b0, wb_en}, 32'h0);
        issue_we = 1'b1;
        idle();
        check("idle_wb_en", {31'b0, wb_en}, 32'h0);
        check("idle_exc_en", {31'b0, exc_en}, 32'h0);

`ifdef CSR_COUNTER_EN
        do_op(3'b001, 12'hB00, 32'hFFFFFFFE, 1'b0, 6'd25);
        idle();
        do_op(3'b010, 12'hB00, 32'h0, 1'b1, 6'd26);
        check("mcycle_pre_wrap", wb_data, 32'hFFFFFFFF);
        do_op(3'b010, 12'hB00, 32'h0, 1'b1, 6'd27);
        check("mcycle_wrap", wb_data, 32'h0);
        commit_num = 3'd3;
        do_op(3'b001, 12'hB02, 32'd100, 1'b0, 6'd28);
        repeat (4) idle();
        commit_num = 3'd0;
        do_op(3'b010, 12'hB02, 32'h0, 1'b1, 6'd29);
        check("minstret_plus12", wb_data, 32'd112);
`else
        do_op(3'b010, 12'hB00, 32'h0, 1'b1, 6'd25);
        check("mcycle_absent_exc", {31'b0, exc_en}, 32'h1);
        check("mcycle_absent_cause", {27'b0, exc_cause}, 32'd2);
        do_op(3'b010, 12'hB02, 32'h0, 1'b1, 6'd26);
        check("minstret_absent_exc", {31'b0, exc_en}, 32'h1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
